// File: rtl/ram_dump_ctrl_pkg.sv
// Shared types for the post-halt RAM dump controller and its byte serializer.
package ram_dump_ctrl_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT   = 3'd1,
      READ    = 3'd2,
      SEND    = 3'd3,
      RELEASE = 3'd4,
      DONE    = 3'd5
   } dump_state_t;

endpackage

// File: rtl/ram_dump_ctrl_if.sv
// RAM debug-port override and UART TX handshake seen by the dump controller.
interface ram_dump_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   import ram_dump_ctrl_pkg::*;

   logic              override_ctrl;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_ren;
   word_t             ram_rdata;
   logic              ram_ready;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output override_ctrl, ram_addr, ram_ren, tx_data, tx_valid,
      input  ram_rdata, ram_ready, tx_ready
   );

   modport slave (
      input  override_ctrl, ram_addr, ram_ren, tx_data, tx_valid,
      output ram_rdata, ram_ready, tx_ready
   );

endinterface

// File: rtl/dump_word_ser.sv
// Holds one RAM word and presents it LSB-first as 4 bytes on a valid/ready handshake.
module dump_word_ser
   import ram_dump_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  word_t      word_in,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       last_byte_accepted
);

   localparam int unsigned BI_W = $clog2(BYTES_PER_WORD);

   word_t           word_q, word_d;
   logic [BI_W-1:0] byte_idx_q, byte_idx_d;
   logic            valid_q, valid_d;
   logic            accept;

   assign accept             = valid_q & tx_ready;
   assign last_byte_accepted = accept && (byte_idx_q == BI_W'(BYTES_PER_WORD - 1));
   assign tx_valid           = valid_q;
   assign tx_data            = word_q[{byte_idx_q, 3'b000} +: 8];

   always_comb begin
      word_d     = word_q;
      byte_idx_d = byte_idx_q;
      valid_d    = valid_q;
      if (load) begin
         word_d     = word_in;
         byte_idx_d = '0;
         valid_d    = 1'b1;
      end else if (accept) begin
         if (last_byte_accepted) begin
            byte_idx_d = '0;
            valid_d    = 1'b0;
         end else begin
            byte_idx_d = byte_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q     <= '0;
         byte_idx_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         word_q     <= word_d;
         byte_idx_q <= byte_idx_d;
         valid_q    <= valid_d;
      end
   end

endmodule

// File: rtl/ram_dump_ctrl.sv
// Takes the RAM override on CPU halt or a start pulse and streams NUM_WORDS words
// from BASE_ADDR out over the UART TX handshake, little-endian.
module ram_dump_ctrl
   import ram_dump_ctrl_pkg::*;
#(
   parameter int unsigned          ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
   parameter int unsigned          NUM_WORDS = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            halt,
   input  logic            dump_start,
   ram_dump_ctrl_if.master bus,
   output logic            busy,
   output logic            done
);

   localparam int unsigned      IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   dump_state_t      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             halt_q;
   logic             trigger;
   logic             load;
   logic             last_acc;
   logic             owned;

   assign trigger = (halt & ~halt_q) | dump_start;
   assign load    = (state_q == READ) && bus.ram_ready;

   // Outputs decode straight from state so a reset drops the override on the next cycle.
   assign owned             = (state_q == GRANT) || (state_q == READ) || (state_q == SEND);
   assign bus.override_ctrl = owned;
   assign bus.ram_ren       = (state_q == READ);
   assign bus.ram_addr      = BASE_ADDR + (ADDR_W'(idx_q) << 2);
   assign busy              = owned;
   assign done              = (state_q == RELEASE) || (state_q == DONE);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE, DONE: begin
            if (trigger) begin
               state_d = GRANT;
               idx_d   = '0;
            end
         end
         GRANT:   state_d = READ;
         READ:    if (bus.ram_ready) state_d = SEND;
         SEND: begin
            if (last_acc) begin
               if (idx_q == LAST_IDX) begin
                  state_d = RELEASE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = READ;
               end
            end
         end
         RELEASE: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         halt_q  <= halt;
      end
   end

   dump_word_ser u_ser (
      .clk                (clk),
      .rst                (rst),
      .load               (load),
      .word_in            (bus.ram_rdata),
      .tx_data            (bus.tx_data),
      .tx_valid           (bus.tx_valid),
      .tx_ready           (bus.tx_ready),
      .last_byte_accepted (last_acc)
   );

endmodule

// File: tb/tb_ram_dump_ctrl.sv
// Directed bench for ram_dump_ctrl: a 2-word dump at 0x100 plus a 12-bit wrap-around instance.
module tb_ram_dump_ctrl;

   typedef struct {
      string name;
      int    rd_wait;
      int    stall_byte;
      int    stall_len;
      bit    use_halt;
      int    exp_lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic halt_a = 1'b0, start_a = 1'b0, busy_a, done_a;
   logic halt_b = 1'b0, start_b = 1'b0, busy_b, done_b;

   int n_checks = 0;
   int n_fail   = 0;

   ram_dump_ctrl_if #(.ADDR_W(32)) ifa ();
   ram_dump_ctrl_if #(.ADDR_W(12)) ifb ();

   ram_dump_ctrl #(.ADDR_W(32), .BASE_ADDR(32'h0000_0100), .NUM_WORDS(2)) dut_a (
      .clk(clk), .rst(rst), .halt(halt_a), .dump_start(start_a),
      .bus(ifa), .busy(busy_a), .done(done_a)
   );

   ram_dump_ctrl #(.ADDR_W(12), .BASE_ADDR(12'hFFC), .NUM_WORDS(2)) dut_b (
      .clk(clk), .rst(rst), .halt(halt_b), .dump_start(start_b),
      .bus(ifb), .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   // RAM and UART models for instance A
   int rd_wait = 0, stall_byte = 0, stall_len = 0;
   int rd_cnt = 0, acc_cnt = 0, stall_cnt = 0;
   int hs_err = 0, ram_err = 0, ovl_err = 0, done_rise = 0;
   logic       pv_valid = 0, pv_ready = 0, pv_ren = 0, pv_rdy = 0, pv_done = 0;
   logic [7:0] pv_data = 0;
   logic [31:0] pv_addr = 0;
   logic [7:0]  bytes_a[$];
   logic [7:0]  stall_bytes[$];
   logic [31:0] addrs_a[$];

   function automatic logic [31:0] mem_a(input logic [31:0] a);
      case (a)
         32'h100: mem_a = 32'h1122_3344;
         32'h104: mem_a = 32'hAABB_CCDD;
         default: mem_a = 32'hBAD0_0000;
      endcase
   endfunction

   assign ifa.ram_ready = ifa.ram_ren && (rd_cnt >= rd_wait);
   assign ifa.ram_rdata = mem_a(ifa.ram_addr);
   assign ifa.tx_ready  = !(stall_len != 0 && acc_cnt == stall_byte && stall_cnt < stall_len);

   always @(posedge clk) begin
      if (ifa.tx_valid && ifa.tx_ready) begin
         bytes_a.push_back(ifa.tx_data);
         acc_cnt   <= acc_cnt + 1;
         stall_cnt <= 0;
      end else if (ifa.tx_valid) begin
         stall_bytes.push_back(ifa.tx_data);
         stall_cnt <= stall_cnt + 1;
      end
      if (ifa.ram_ren && ifa.ram_ready) addrs_a.push_back(ifa.ram_addr);
      rd_cnt <= (ifa.ram_ren && !ifa.ram_ready) ? rd_cnt + 1 : 0;
      if (pv_valid && !pv_ready && (!ifa.tx_valid || ifa.tx_data != pv_data)) hs_err <= hs_err + 1;
      if (pv_ren && !pv_rdy && (!ifa.ram_ren || ifa.ram_addr != pv_addr)) ram_err <= ram_err + 1;
      if ((ifa.tx_valid && ifa.ram_ren) || (ifa.ram_ren && !ifa.override_ctrl)) ovl_err <= ovl_err + 1;
      if (done_a && !pv_done) done_rise <= done_rise + 1;
      pv_valid <= ifa.tx_valid;
      pv_ready <= ifa.tx_ready;
      pv_data  <= ifa.tx_data;
      pv_ren   <= ifa.ram_ren;
      pv_rdy   <= ifa.ram_ready;
      pv_addr  <= ifa.ram_addr;
      pv_done  <= done_a;
   end

   // Instance B: zero-wait RAM returning a tag plus the address, UART always ready
   logic [7:0]  bytes_b[$];
   logic [11:0] addrs_b[$];

   assign ifb.ram_ready = ifb.ram_ren;
   assign ifb.ram_rdata = 32'hC0DE_0000 | {20'h0, ifb.ram_addr};
   assign ifb.tx_ready  = 1'b1;

   always @(posedge clk) begin
      if (ifb.tx_valid && ifb.tx_ready) bytes_b.push_back(ifb.tx_data);
      if (ifb.ram_ren && ifb.ram_ready) addrs_b.push_back(ifb.ram_addr);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      halt_a  = 0; start_a = 0; halt_b = 0; start_b = 0;
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   task automatic clear_mon();
      rd_cnt = 0; acc_cnt = 0; stall_cnt = 0;
      hs_err = 0; ram_err = 0; ovl_err = 0; done_rise = 0;
      pv_valid = 0; pv_ready = 0; pv_ren = 0; pv_rdy = 0; pv_done = 0;
      bytes_a.delete(); stall_bytes.delete(); addrs_a.delete();
   endtask

   task automatic wait_done_a(input string name);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (done_a) break;
      end
      check({name, " done"}, done_a, 1'b1);
   endtask

   logic [7:0] exp_bytes[8];
   vec_t       vecs[4];

   task automatic check_stream(input string name);
      check({name, " nbytes"}, bytes_a.size(), 8);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s byte%0d", name, i), bytes_a[i], exp_bytes[i]);
      check({name, " naddr"}, addrs_a.size(), 2);
      check({name, " addr0"}, addrs_a[0], 32'h100);
      check({name, " addr1"}, addrs_a[1], 32'h104);
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      do_reset();
      rd_wait = v.rd_wait; stall_byte = v.stall_byte; stall_len = v.stall_len;
      clear_mon();
      @(negedge clk);
      if (v.use_halt) halt_a = 1; else start_a = 1;
      lat = 99;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         start_a = 0;
         if (ifa.tx_valid) begin
            lat = k;
            break;
         end
      end
      check({v.name, " latency"}, lat, v.exp_lat);
      wait_done_a(v.name);
      check({v.name, " override"}, ifa.override_ctrl, 1'b0);
      check({v.name, " busy"}, busy_a, 1'b0);
      repeat (2) @(posedge clk); #1;
      check_stream(v.name);
      check({v.name, " done_once"}, done_rise, 1);
      check({v.name, " tx_hold"}, hs_err, 0);
      check({v.name, " ram_hold"}, ram_err, 0);
      check({v.name, " overlap"}, ovl_err, 0);
      check({v.name, " nstall"}, stall_bytes.size(), v.stall_len);
      for (int i = 0; i < stall_bytes.size(); i++)
         check($sformatf("%s stall%0d", v.name, i), stall_bytes[i], exp_bytes[v.stall_byte]);
   endtask

   initial begin
      exp_bytes = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
      vecs[0] = '{name: "basic_halt",   rd_wait: 0, stall_byte: 0, stall_len: 0, use_halt: 1, exp_lat: 3};
      vecs[1] = '{name: "backpressure", rd_wait: 0, stall_byte: 1, stall_len: 5, use_halt: 0, exp_lat: 3};
      vecs[2] = '{name: "ram_wait",     rd_wait: 4, stall_byte: 0, stall_len: 0, use_halt: 0, exp_lat: 7};
      vecs[3] = '{name: "wait_stall",   rd_wait: 2, stall_byte: 6, stall_len: 3, use_halt: 1, exp_lat: 5};

      // Reset state
      do_reset();
      clear_mon();
      check("rst override", ifa.override_ctrl, 1'b0);
      check("rst ren", ifa.ram_ren, 1'b0);
      check("rst tx_valid", ifa.tx_valid, 1'b0);
      check("rst tx_data", ifa.tx_data, 8'h00);
      check("rst busy", busy_a, 1'b0);
      check("rst done", done_a, 1'b0);
      check("rst addr", ifa.ram_addr, 32'h100);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Retrigger attempts while busy must not start a second dump
      do_reset();
      rd_wait = 0; stall_len = 0;
      clear_mon();
      @(negedge clk); start_a = 1;
      @(negedge clk); start_a = 0;
      @(negedge clk); halt_a = 1;
      @(negedge clk); start_a = 1;
      @(negedge clk); start_a = 0; halt_a = 0;
      @(negedge clk); halt_a = 1;
      @(negedge clk); halt_a = 0;
      wait_done_a("retrig");
      repeat (5) @(posedge clk); #1;
      check_stream("retrig");
      check("retrig done_once", done_rise, 1);
      check("retrig done_held", done_a, 1'b1);
      check("retrig busy", busy_a, 1'b0);

      // Reset during SEND of word 1, then a clean restart
      do_reset();
      rd_wait = 0; stall_len = 0;
      clear_mon();
      @(negedge clk); start_a = 1;
      @(negedge clk); start_a = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (bytes_a.size() == 5 && ifa.tx_valid) break;
      end
      check("midrst in_send", ifa.tx_valid, 1'b1);
      rst = 1;
      @(posedge clk); #1;
      check("midrst override", ifa.override_ctrl, 1'b0);
      check("midrst tx_valid", ifa.tx_valid, 1'b0);
      check("midrst busy", busy_a, 1'b0);
      check("midrst done", done_a, 1'b0);
      check("midrst ren", ifa.ram_ren, 1'b0);
      @(negedge clk); rst = 0;
      clear_mon();
      @(negedge clk); start_a = 1;
      @(negedge clk); start_a = 0;
      wait_done_a("restart");
      repeat (2) @(posedge clk); #1;
      check_stream("restart");

      // Address wrap in a 12-bit space
      do_reset();
      bytes_b.delete(); addrs_b.delete();
      @(negedge clk); start_b = 1;
      @(negedge clk); start_b = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (done_b) break;
      end
      check("wrap done", done_b, 1'b1);
      check("wrap override", ifb.override_ctrl, 1'b0);
      check("wrap nbytes", bytes_b.size(), 8);
      check("wrap naddr", addrs_b.size(), 2);
      check("wrap addr0", addrs_b[0], 12'hFFC);
      check("wrap addr1", addrs_b[1], 12'h000);
      check("wrap byte0", bytes_b[0], 8'hFC);
      check("wrap byte1", bytes_b[1], 8'h0F);
      check("wrap byte3", bytes_b[3], 8'hC0);
      check("wrap byte4", bytes_b[4], 8'h00);
      check("wrap byte6", bytes_b[6], 8'hDE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_dump_ctrl.md
Name: ram_dump_ctrl

Overview:
- Sequences a post-halt memory dump of the system RAM over the UART transmitter.
- On CPU halt, or on an explicit start pulse, it takes the RAM override, reads NUM_WORDS words from BASE_ADDR, and streams each word little-endian byte-by-byte to the UART TX handshake.
- It drives the override_ctrl/addr/ren side of the RAM debug interface in the FPGA system top, replacing the constant-0 override tie-off.

Parameters:
ADDR_W, 32, RAM byte-address width
BASE_ADDR, 32'h0000_0000, first byte address dumped (word aligned)
NUM_WORDS, 1024, number of 32-bit words dumped (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
halt  in  1  CPU halt level
dump_start  in  1  single-cycle manual dump request
override_ctrl  out  1  RAM override grant; 1 = this block owns the RAM port
ram_addr  out  ADDR_W  RAM byte address
ram_ren  out  1  RAM read request
ram_rdata  in  32  RAM read data
ram_ready  in  1  RAM read complete; ram_rdata valid this cycle
tx_data  out  8  byte to UART TX
tx_valid  out  1  byte valid
tx_ready  in  1  UART TX accepts byte when tx_valid & tx_ready
busy  out  1  dump in progress
done  out  1  dump finished; held until the next trigger

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; override_ctrl, ram_ren, tx_valid, busy, done = 0; ram_addr=BASE_ADDR; tx_data=0; word index=0; halt_q=0.
- Trigger: (halt & ~halt_q) | dump_start, where halt_q is halt registered each cycle. Triggers are accepted only in IDLE or DONE and ignored while busy. A simultaneous halt edge and dump_start produces one dump.
- FSM:
  - IDLE/DONE --trigger--> GRANT. Trigger clears done and zeroes the index.
  - GRANT, 1 cycle: override_ctrl=1, busy=1, ram_ren=0. This guarantees one override-setup cycle before the first access.
  - READ: ram_ren=1, ram_addr=BASE_ADDR + 4*index, truncated to ADDR_W (wrap-around is permitted and not flagged). Stay in READ until ram_ready. On ram_ready, latch ram_rdata into word_q, drop ram_ren the next cycle, and go to SEND with byte_idx=0.
  - SEND: tx_valid=1, tx_data=word_q[8*byte_idx+:8], so byte 0 (LSB) goes first. On tx_valid & tx_ready, increment byte_idx. After byte 3 is accepted:
    - index==NUM_WORDS-1 → RELEASE
    - otherwise index++ → READ
  - RELEASE, 1 cycle: override_ctrl=0, busy=0, done=1 → DONE.
  - DONE: done=1 until the next trigger or reset.
- Handshake rules:
  - tx_data and tx_valid stay stable while tx_valid & ~tx_ready.
  - tx_valid never deasserts without an acceptance.
  - The next byte may be presented the cycle after acceptance, giving at most 1 byte per cycle.
- override_ctrl is 1 from GRANT through the last SEND byte inclusive and 0 in IDLE/RELEASE/DONE. ram_ren is asserted only while override_ctrl=1.
- Deasserting halt mid-dump is ignored; the dump completes.
- rst mid-dump: next cycle returns to reset values, releasing the override immediately. A partial byte stream is acceptable.
- NUM_WORDS=1: GRANT→READ→SEND×4→RELEASE.
- Latency, trigger to first tx_valid with ram_ready in 1 cycle: trigger cycle T, GRANT T+1, READ T+2 (ready), SEND T+3.

Decomposition:
- common_types_pkg gains:
  - dump_state_t enum {IDLE, GRANT, READ, SEND, RELEASE, DONE}
  - word_t (32-bit), if not already present
  - BYTES_PER_WORD=4
- Natural sub-module: dump_word_ser. It loads a 32-bit word, emits 4 bytes LSB-first on a valid/ready handshake, and pulses last_byte_accepted. The FSM, addressing and override live in ram_dump_ctrl.

Test Plan:
- NUM_WORDS=2, BASE_ADDR=0x100, RAM[0x100]=0x11223344, RAM[0x104]=0xAABBCCDD, tx_ready=1, ram_ready one cycle after ren, halt rises → bytes 44,33,22,11,DD,CC,BB,AA; addresses 0x100 then 0x104; first tx_valid 3 cycles after the trigger; done=1 and override_ctrl=0 after the last byte.
- UART backpressure: tx_ready low for 5 cycles on the 2nd byte → tx_data holds 0x33 with tx_valid=1 throughout; no byte is lost or duplicated.
- RAM wait states: ram_ready delayed 4 cycles → ram_ren and ram_addr hold steady; tx_valid stays 0 until the data is latched.
- dump_start pulse while busy, and halt toggling mid-dump → exactly one dump of NUM_WORDS×4 bytes; done asserts once.
- rst=1 during SEND of word 1 → next cycle override_ctrl=0, tx_valid=0, busy=0, done=0. A later dump_start restarts from BASE_ADDR.
- ADDR_W=12, BASE_ADDR=0xFFC, NUM_WORDS=2 → addresses 0xFFC then 0x000 (wrap), 8 bytes sent, done=1.
